// File: rtl/axi4_sub_mem.sv
// AXI4-Lite subordinate scratch memory: word-addressed, byte-strobed, SLVERR when out of range.
// Latency: B one edge after the last AW/W handshake; R one edge after the AR handshake.
// Backpressure: a held B stalls only AW/W and a held R stalls only AR; readies return the edge after B/R handshake.
//
// Ports:
//   ACLK, ARESETn              clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY     write address channel
//   WDATA/WSTRB/WVALID/WREADY  write data channel
//   BRESP/BVALID/BREADY        write response channel (00 OKAY, 10 SLVERR)
//   ARADDR/ARVALID/ARREADY     read address channel
//   RDATA/RRESP/RVALID/RREADY  read data channel (00 OKAY, 10 SLVERR)
module axi4_sub_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_W-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFS_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  // One past the last valid byte address; one extra bit so the compare cannot wrap.
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH * STRB_W);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } wbeat_t;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= ADDR_LIMIT;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- write side
  wstate_t           w_state, w_next;
  logic [ADDR_W-1:0] aw_addr_q;
  wbeat_t            w_beat_q;
  logic              wr_commit;
  logic [ADDR_W-1:0] wr_addr;
  wbeat_t            wr_beat;
  logic              aw_hs, w_hs, b_hs;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign b_hs  = BVALID && BREADY;

  // Commit takes whichever half arrives on this edge straight from the bus and
  // the other half from its holding register.
  always_comb begin
    w_next    = w_state;
    wr_commit = 1'b0;
    wr_addr   = aw_addr_q;
    wr_beat   = w_beat_q;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_commit    = 1'b1;
          wr_addr      = AWADDR;
          wr_beat.data = WDATA;
          wr_beat.strb = WSTRB;
          w_next       = W_RESP;
        end else if (aw_hs) begin
          w_next = W_HAVE_AW;
        end else if (w_hs) begin
          w_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          wr_commit    = 1'b1;
          wr_beat.data = WDATA;
          wr_beat.strb = WSTRB;
          w_next       = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          wr_commit = 1'b1;
          wr_addr   = AWADDR;
          w_next    = W_RESP;
        end
      end
      W_RESP: begin
        if (b_hs) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Readies and BVALID are registered copies of what the next state allows.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state   <= W_IDLE;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      aw_addr_q <= '0;
      w_beat_q  <= '0;
    end else begin
      w_state <= w_next;
      AWREADY <= (w_next == W_IDLE) || (w_next == W_HAVE_W);
      WREADY  <= (w_next == W_IDLE) || (w_next == W_HAVE_AW);
      BVALID  <= (w_next == W_RESP);
      if (wr_commit) BRESP <= addr_oor(wr_addr) ? RESP_SLVERR : RESP_OKAY;
      if (aw_hs) aw_addr_q <= AWADDR;
      if (w_hs) begin
        w_beat_q.data <= WDATA;
        w_beat_q.strb <= WSTRB;
      end
    end
  end

  // Storage is deliberately not reset. Commit is gated by the readies, which
  // drop asynchronously, so nothing is written while reset is asserted.
  always_ff @(posedge ACLK) begin
    if (wr_commit && !addr_oor(wr_addr)) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_beat.strb[i]) mem[wr_addr[OFS_W +: IDX_W]][8*i +: 8] <= wr_beat.data[8*i +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read side
  rstate_t r_state, r_next;
  logic    ar_hs, r_hs;

  assign ar_hs = ARVALID && ARREADY;
  assign r_hs  = RVALID && RREADY;

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_RESP;
      R_RESP:  if (r_hs)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // The array read samples pre-edge contents, so a write committing on the
  // same edge to the same word is not visible to this read.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      ARREADY <= (r_next == R_IDLE);
      RVALID  <= (r_next == R_RESP);
      if (ar_hs) begin
        if (addr_oor(ARADDR)) begin
          RDATA <= '0;
          RRESP <= RESP_SLVERR;
        end else begin
          RDATA <= mem[ARADDR[OFS_W +: IDX_W]];
          RRESP <= RESP_OKAY;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi4_sub_mem.sv
module tb_axi4_sub_mem;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int NWORDS = 256;
  localparam int NBYTES = NWORDS * SW;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [AW-1:0] AWADDR = '0;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [SW-1:0] WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b1;
  logic [AW-1:0] ARADDR = '0;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b1;

  axi4_sub_mem #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(NWORDS)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  typedef struct { logic [63:0] d; logic [1:0] resp; } rexp_t;
  typedef struct { logic [63:0] d; logic [7:0] s; } wbeat_t;

  logic [63:0]  mm [NWORDS];
  logic [AW-1:0] aw_q [$];
  wbeat_t       w_q [$];
  logic [1:0]   b_q [$];
  rexp_t        r_q [$];
  int           since_rst;
  bit           e_awr, e_wr, e_arr;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) since_rst <= 0;
    else if (since_rst < 2) since_rst <= since_rst + 1;
  end

  // At each falling edge: compare outputs with the model's view of the
  // transactions in flight, then account for handshakes that the coming rising
  // edge will perform. Reads see memory before any write on the same edge.
  always @(negedge ACLK) begin
    rexp_t re;
    wbeat_t wb;
    logic [AW-1:0] a;
    int idx;
    if (!ARESETn) begin
      chk("rst_awready", 64'(AWREADY), 64'd0);
      chk("rst_wready",  64'(WREADY),  64'd0);
      chk("rst_arready", 64'(ARREADY), 64'd0);
      chk("rst_bvalid",  64'(BVALID),  64'd0);
      chk("rst_rvalid",  64'(RVALID),  64'd0);
      chk("rst_bresp",   64'(BRESP),   64'd0);
      chk("rst_rresp",   64'(RRESP),   64'd0);
      chk("rst_rdata",   RDATA,        64'd0);
      aw_q.delete(); w_q.delete(); b_q.delete(); r_q.delete();
    end else begin
      e_awr = (since_rst > 0) && aw_q.size() == 0 && b_q.size() == 0;
      e_wr  = (since_rst > 0) && w_q.size() == 0 && b_q.size() == 0;
      e_arr = (since_rst > 0) && r_q.size() == 0;
      chk("awready", 64'(AWREADY), 64'(e_awr));
      chk("wready",  64'(WREADY),  64'(e_wr));
      chk("arready", 64'(ARREADY), 64'(e_arr));
      chk("bvalid",  64'(BVALID),  64'(b_q.size() != 0));
      chk("rvalid",  64'(RVALID),  64'(r_q.size() != 0));
      if (b_q.size() != 0) chk("bresp", 64'(BRESP), 64'(b_q[0]));
      if (r_q.size() != 0) begin
        chk("rdata", RDATA, r_q[0].d);
        chk("rresp", 64'(RRESP), 64'(r_q[0].resp));
      end
      if (b_q.size() != 0 && BREADY) void'(b_q.pop_front());
      if (r_q.size() != 0 && RREADY) void'(r_q.pop_front());
      if (ARVALID && e_arr) begin
        if (ARADDR >= NBYTES) begin re.d = '0; re.resp = 2'b10; end
        else begin re.d = mm[(ARADDR / SW) % NWORDS]; re.resp = 2'b00; end
        r_q.push_back(re);
      end
      if (AWVALID && e_awr) aw_q.push_back(AWADDR);
      if (WVALID && e_wr) begin wb.d = WDATA; wb.s = WSTRB; w_q.push_back(wb); end
      if (aw_q.size() != 0 && w_q.size() != 0) begin
        a  = aw_q.pop_front();
        wb = w_q.pop_front();
        if (a >= NBYTES) b_q.push_back(2'b10);
        else begin
          idx = (a / SW) % NWORDS;
          for (int i = 0; i < SW; i++) if (wb.s[i]) mm[idx][8*i +: 8] = wb.d[8*i +: 8];
          b_q.push_back(2'b00);
        end
      end
    end
  end

  // ------------------------------------------------------------------ drivers
  task automatic wr(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] s,
                    input int aw_dly, input int w_dly, input bit wait_b, output logic [1:0] resp);
    int cyc = 0;
    int lat = 0;
    bit aw_done = 0, w_done = 0;
    @(posedge ACLK); #1;
    while (!(aw_done && w_done) && cyc < 50) begin
      AWVALID = !aw_done && cyc >= aw_dly; AWADDR = a;
      WVALID  = !w_done && cyc >= w_dly;   WDATA = d; WSTRB = s;
      @(negedge ACLK);
      if (w_done && !aw_done) begin
        chk("wfirst_wready", 64'(WREADY), 64'd0);
        chk("wfirst_awready", 64'(AWREADY), 64'd1);
      end
      if (AWVALID && AWREADY) aw_done = 1;
      if (WVALID && WREADY) w_done = 1;
      @(posedge ACLK); #1;
      cyc++;
    end
    AWVALID = 0; WVALID = 0;
    chk("wr_handshake", 64'(aw_done && w_done), 64'd1);
    resp = 2'b00;
    if (wait_b) begin
      do begin @(negedge ACLK); lat++; end while (!BVALID && lat < 100);
      chk("b_latency", 64'(lat), 64'd1);
      resp = BRESP;
      @(posedge ACLK); #1;
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [63:0] d, output logic [1:0] resp);
    int cyc = 0;
    int lat = 0;
    bit hs = 0;
    @(posedge ACLK); #1;
    ARVALID = 1; ARADDR = a;
    while (!hs && cyc < 50) begin
      @(negedge ACLK);
      hs = ARREADY;
      @(posedge ACLK); #1;
      cyc++;
    end
    ARVALID = 0;
    chk("rd_handshake", 64'(hs), 64'd1);
    do begin @(negedge ACLK); lat++; end while (!RVALID && lat < 100);
    chk("r_latency", 64'(lat), 64'd1);
    d = RDATA; resp = RRESP;
    @(posedge ACLK); #1;
  endtask

  task automatic do_reset();
    @(posedge ACLK); #1;
    ARESETn = 0; AWVALID = 0; WVALID = 0; ARVALID = 0;
    @(negedge ACLK);
    chk("in_rst_bvalid", 64'(BVALID), 64'd0);
    chk("in_rst_rvalid", 64'(RVALID), 64'd0);
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1;
    @(negedge ACLK);
    chk("rel_awready_early", 64'(AWREADY), 64'd0);
    @(negedge ACLK);
    chk("rel_awready", 64'(AWREADY), 64'd1);
    chk("rel_wready",  64'(WREADY),  64'd1);
    chk("rel_arready", 64'(ARREADY), 64'd1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    case ($urandom_range(0, 9))
      0:             a = 32'(NBYTES) + 32'($urandom_range(0, 4095));
      1, 2, 3, 4, 5: a = 32'($urandom_range(0, 7) * SW);
      default:       a = 32'($urandom_range(0, NWORDS - 1) * SW);
    endcase
    return a + 32'($urandom_range(0, SW - 1));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  logic [63:0] dd, dd2;
  logic [1:0]  rr, rr2, bb;

  initial begin
    bit aw_hs, w_hs, ar_hs, done;
    do_reset();

    for (int i = 0; i < NWORDS; i++) wr(32'(i * SW), {$urandom, $urandom}, 8'hFF, 0, 0, 1, bb);

    // full-width write and read back
    wr(32'h10, 64'h1122334455667788, 8'hFF, 0, 0, 1, bb);
    chk("w10_bresp", 64'(bb), 64'd0);
    rd(32'h10, dd, rr);
    chk("r10_data", dd, 64'h1122334455667788);
    chk("r10_resp", 64'(rr), 64'd0);

    // W first, AW three cycles later, lower four lanes only
    wr(32'h10, 64'hAAAAAAAABBBBBBBB, 8'h0F, 3, 0, 1, bb);
    chk("partial_bresp", 64'(bb), 64'd0);
    chk("model_word2", mm[2], 64'h11223344BBBBBBBB);
    rd(32'h10, dd, rr);
    chk("partial_data", dd, 64'h11223344BBBBBBBB);
    rd(32'h13, dd, rr);
    chk("unaligned_data", dd, 64'h11223344BBBBBBBB);

    // out of range: 0x800 would alias word 0 if the range check were missing
    wr(32'h0, 64'h00000000CAFEF00D, 8'hFF, 0, 0, 1, bb);
    wr(32'h800, 64'hDEADBEEFDEADBEEF, 8'hFF, 0, 0, 1, bb);
    chk("oor_bresp", 64'(bb), 64'd2);
    rd(32'h0, dd, rr);
    chk("oor_mem_unchanged", dd, 64'h00000000CAFEF00D);
    rd(32'h800, dd, rr);
    chk("oor_rdata", dd, 64'd0);
    chk("oor_rresp", 64'(rr), 64'd2);

    // zero strobe writes nothing, still OKAY
    wr(32'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00, 0, 0, 1, bb);
    chk("zstrb_bresp", 64'(bb), 64'd0);
    rd(32'h10, dd, rr);
    chk("zstrb_data", dd, 64'h11223344BBBBBBBB);

    // B stalled: response held, write readies low, reads still served
    BREADY = 0;
    wr(32'h20, 64'h5555, 8'hFF, 0, 0, 0, bb);
    repeat (5) begin
      @(negedge ACLK);
      chk("stall_bvalid", 64'(BVALID), 64'd1);
      chk("stall_bresp", 64'(BRESP), 64'd0);
      chk("stall_awready", 64'(AWREADY), 64'd0);
      chk("stall_wready", 64'(WREADY), 64'd0);
    end
    rd(32'h10, dd, rr);
    chk("stall_read_data", dd, 64'h11223344BBBBBBBB);
    BREADY = 1;
    @(negedge ACLK);
    chk("stall_bvalid_end", 64'(BVALID), 64'd1);
    @(posedge ACLK); #1;
    @(negedge ACLK);
    chk("after_b_bvalid", 64'(BVALID), 64'd0);
    chk("after_b_awready", 64'(AWREADY), 64'd1);

    // same-edge write commit and read of the same word
    wr(32'h18, 64'h1, 8'hFF, 0, 0, 1, bb);
    fork
      wr(32'h18, 64'h2, 8'hFF, 0, 0, 1, bb);
      rd(32'h18, dd2, rr2);
    join
    chk("collide_old", dd2, 64'h1);
    rd(32'h18, dd, rr);
    chk("collide_new", dd, 64'h2);

    // randomized traffic on all channels
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      aw_hs = AWVALID && AWREADY; w_hs = WVALID && WREADY; ar_hs = ARVALID && ARREADY;
      @(posedge ACLK); #1;
      if (!AWVALID || aw_hs) begin AWVALID = $urandom_range(0, 1) != 0; AWADDR = rand_addr(); end
      if (!WVALID || w_hs) begin
        WVALID = $urandom_range(0, 1) != 0;
        WDATA = {$urandom, $urandom};
        case ($urandom_range(0, 3))
          0: WSTRB = 8'h00;
          1: WSTRB = 8'hFF;
          default: WSTRB = 8'($urandom);
        endcase
      end
      if (!ARVALID || ar_hs) begin ARVALID = $urandom_range(0, 1) != 0; ARADDR = rand_addr(); end
      BREADY = $urandom_range(0, 3) != 0;
      RREADY = $urandom_range(0, 3) != 0;
    end
    done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge ACLK);
      aw_hs = AWVALID && AWREADY; w_hs = WVALID && WREADY; ar_hs = ARVALID && ARREADY;
      done = !AWVALID && !WVALID && !ARVALID && !BVALID && !RVALID;
      @(posedge ACLK); #1;
      if (aw_hs) AWVALID = 0;
      if (w_hs) WVALID = 0;
      if (ar_hs) ARVALID = 0;
      BREADY = 1; RREADY = 1;
    end
    chk("drain_done", 64'(done), 64'd1);

    // reset with a committed write whose B is still pending
    BREADY = 0;
    wr(32'h28, 64'h2828282828282828, 8'hFF, 0, 0, 0, bb);
    do_reset();
    BREADY = 1;
    rd(32'h28, dd, rr);
    chk("rst_committed_kept", dd, 64'h2828282828282828);

    // reset with only AW accepted: write must be dropped
    wr(32'h30, 64'h3030303030303030, 8'hFF, 0, 0, 1, bb);
    @(posedge ACLK); #1;
    AWVALID = 1; AWADDR = 32'h30; WDATA = 64'hDEAD; WSTRB = 8'hFF;
    @(negedge ACLK);
    chk("half_aw_ready", 64'(AWREADY), 64'd1);
    @(posedge ACLK); #1;
    AWVALID = 0;
    do_reset();
    rd(32'h30, dd, rr);
    chk("rst_uncommitted_dropped", dd, 64'h3030303030303030);

    repeat (3) @(posedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
